feature_deserializer: RTL

Upstream stage of the sensor-fusion classifier. It accepts one quantized channel feature per cycle from the sensor front end and assembles a complete window of all GSR, ECG and EEG channels. It presents that window to the classifier top as the parallel `features` array with a `fin_valid`/`fin_ready` handshake. It is double-buffered, so the next window can stream in while the classifier holds the current one.

---
 rtl/feature_deserializer.sv | 103 ++++++++++
 1 files changed

// File: rtl/feature_deserializer.sv
// Collects one quantized channel feature per cycle into a full GSR/ECG/EEG window
// and hands it to the classifier as a parallel array. A fill buffer plus an output buffer give double buffering.
`ifndef TOTAL_NUM_CHANNEL
`define TOTAL_NUM_CHANNEL 4
`endif
`ifndef CHANNEL_WIDTH
`define CHANNEL_WIDTH 2
`endif

module feature_deserializer #(
  parameter int NUM_CHANNEL   = `TOTAL_NUM_CHANNEL,
  parameter int CHANNEL_WIDTH = `CHANNEL_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [CHANNEL_WIDTH-1:0] sin,
  input  logic                     sin_valid,
  output logic                     sin_ready,
  input  logic                     sin_last,
  output logic [CHANNEL_WIDTH-1:0] features [NUM_CHANNEL-1:0],
  output logic                     fin_valid,
  input  logic                     fin_ready,
  output logic                     frame_err
);

  localparam int IDX_W = (NUM_CHANNEL > 1) ? $clog2(NUM_CHANNEL) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHANNEL - 1);

  // Handshakes: a sample moves when sin_valid && sin_ready; a window moves when fin_valid && fin_ready.
  logic [CHANNEL_WIDTH-1:0] fill_q [NUM_CHANNEL-1:0];
  logic [CHANNEL_WIDTH-1:0] out_q  [NUM_CHANNEL-1:0];
  logic [CHANNEL_WIDTH-1:0] out_d  [NUM_CHANNEL-1:0];
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic                     pending_q, pending_d;
  logic                     fin_valid_q, fin_valid_d;
  logic                     frame_err_q;

  logic accept, at_last, normal, complete, ferr, out_hs, out_free;

  assign accept   = sin_valid && !pending_q;
  assign at_last  = (idx_q == LAST_IDX);
  assign normal   = accept && !sin_last && !at_last;
  assign complete = accept && sin_last && at_last;
  assign ferr     = accept && (sin_last != at_last);
  assign out_hs   = fin_valid_q && fin_ready;
  assign out_free = !fin_valid_q || fin_ready;

  always_comb begin
    idx_d       = idx_q;
    pending_d   = pending_q;
    fin_valid_d = fin_valid_q;
    out_d       = out_q;
    if (ferr || complete) begin
      idx_d = '0;
    end else if (normal) begin
      idx_d = idx_q + IDX_W'(1);
    end
    if (complete) begin
      if (out_free) begin
        // The completing sample bypasses the fill buffer straight into the output.
        out_d                  = fill_q;
        out_d[NUM_CHANNEL-1]   = sin;
        fin_valid_d            = 1'b1;
      end else begin
        pending_d = 1'b1;
      end
    end else if (out_hs) begin
      if (pending_q) begin
        out_d     = fill_q;
        pending_d = 1'b0;
      end else begin
        fin_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      idx_q       <= '0;
      pending_q   <= 1'b0;
      fin_valid_q <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_CHANNEL; i++) out_q[i] <= '0;
    end else begin
      idx_q       <= idx_d;
      pending_q   <= pending_d;
      fin_valid_q <= fin_valid_d;
      frame_err_q <= ferr;
      out_q       <= out_d;
    end
  end

  // Fill contents are don't-care after reset, so no reset term here.
  always_ff @(posedge clk) begin
    if (normal || complete) fill_q[idx_q] <= sin;
  end

  assign sin_ready = !pending_q;
  assign features  = out_q;
  assign fin_valid = fin_valid_q;
  assign frame_err = frame_err_q;

endmodule
